// File: rtl/write_port_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Define ARB_BURST_EN to let a grant holder keep the port for up to MAX_BURST beats.
module write_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            write_clk,
  input  logic                            write_reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            write_full,
  output logic                            write_inc,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || MAX_BURST < 1) begin : gen_param_check
    $error("write_port_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IdW-1:0]   grant_id_q, grant_id_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             holder_valid;
  logic             release_grant;

`ifdef ARB_BURST_EN
  localparam int unsigned BcW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BcW-1:0] burst_cnt_q, burst_cnt_d;
  logic           burst_more;
  assign burst_more = 32'(burst_cnt_q) < (MAX_BURST - 1);
`endif

  // Explicit wrap so non-power-of-two NUM_REQ never produces an out-of-range id.
  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    next_id = (id == IdW'(NUM_REQ - 1)) ? '0 : IdW'(id + 1'b1);
  endfunction

  function automatic logic [IdW-1:0] rr_winner(input logic [IdW-1:0] p,
                                               input logic [NUM_REQ-1:0] v);
    int unsigned idx;
    logic        found;
    rr_winner = p;
    found     = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(p) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && v[idx]) begin
        found     = 1'b1;
        rr_winner = IdW'(idx);
      end
    end
  endfunction

  assign holder_valid = req_valid[grant_id_q];

  always_comb begin
    req_ready = '0;
    if (grant_valid_q && !write_full) req_ready[grant_id_q] = 1'b1;
    write_inc  = grant_valid_q & holder_valid & ~write_full;
    write_data = grant_valid_q ? req_data[32'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    release_grant = 1'b0;
`ifdef ARB_BURST_EN
    burst_cnt_d   = burst_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d       = StGrant;
          grant_valid_d = 1'b1;
          grant_id_d    = rr_winner(rr_ptr_q, req_valid);
        end
      end
      StGrant: begin
        // Full stalls everything, including a (not permitted) valid drop.
        if (!write_full) begin
          if (!holder_valid) begin
            state_d       = StIdle;
            grant_valid_d = 1'b0;
`ifdef ARB_BURST_EN
            burst_cnt_d   = '0;
`endif
          end else begin
            rr_ptr_d = next_id(grant_id_q);
`ifdef ARB_BURST_EN
            if (burst_more) begin
              burst_cnt_d = BcW'(burst_cnt_q + 1'b1);
            end else begin
              burst_cnt_d   = '0;
              release_grant = 1'b1;
            end
`else
            release_grant = 1'b1;
`endif
            if (release_grant) begin
              if (|req_valid) begin
                grant_id_d = rr_winner(next_id(grant_id_q), req_valid);
              end else begin
                state_d       = StIdle;
                grant_valid_d = 1'b0;
              end
            end
          end
        end
      end
      default: begin
        state_d       = StIdle;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
`ifdef ARB_BURST_EN
      burst_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
`ifdef ARB_BURST_EN
      burst_cnt_q   <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_write_port_arbiter.sv
// Self-checking bench for write_port_arbiter: vector table plus hand-written corner sequences,
// with a FIFO scoreboard that checks every write strobe against the expected data order.
module tb_write_port_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 8;

  logic            write_clk;
  logic            write_reset_n;
  logic [NReq-1:0] req_valid;
  logic [NReq*Dw-1:0] req_data;
  logic [NReq-1:0] req_ready;
  logic            write_full;
  logic            write_inc;
  logic [Dw-1:0]   write_data;
  logic            grant_valid;
  logic [1:0]      grant_id;

  write_port_arbiter #(
    .NUM_REQ   (NReq),
    .DATA_WIDTH(Dw),
    .MAX_BURST (4)
  ) dut (
    .write_clk    (write_clk),
    .write_reset_n(write_reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_full   (write_full),
    .write_inc    (write_inc),
    .write_data   (write_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic       gv;
    logic [1:0] gid;
    logic       inc;
    logic [3:0] ready;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sbq[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < NReq; i++) req_data[i*Dw +: Dw] = 8'hC0 + 8'(i);
  endtask

  task automatic do_reset();
    write_reset_n = 1'b0;
    req_valid     = '0;
    write_full    = 1'b0;
    repeat (2) @(posedge write_clk);
    #2 write_reset_n = 1'b1;
  endtask

  task automatic add(input logic [3:0] v, input logic f, input logic gv, input logic [1:0] gid,
                     input logic inc, input logic [3:0] rdy);
    vec_t e;
    e.valid = v; e.full = f; e.gv = gv; e.gid = gid; e.inc = inc; e.ready = rdy;
    tbl.push_back(e);
  endtask

  // Scoreboard: every FIFO write must match the next expected beat.
  always @(negedge write_clk) begin
    if (write_reset_n && write_inc) begin
      check("sb_has_expected", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) check("sb_fifo_data", 32'(write_data), 32'(sbq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

`ifdef ARB_BURST_EN
  logic [1:0] burst_seq[9];
`endif

  initial begin
    write_reset_n = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    write_full    = 1'b0;
    #2;
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_write_inc", 32'(write_inc), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_write_data", 32'(write_data), 0);
    do_reset();

    // Reset asserted mid-cycle while granted and all valid.
    step(); req_valid = 4'hF; set_data(); #3;
    check("mid_idle_gv", 32'(grant_valid), 0);
    step(); sbq.push_back(8'hC0); #3;
    check("mid_first_inc", 32'(write_inc), 1);
    check("mid_first_gid", 32'(grant_id), 0);
    step(); #1 write_reset_n = 1'b0; #1;
    check("mid_rst_inc", 32'(write_inc), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_gv", 32'(grant_valid), 0);
    check("mid_rst_data", 32'(write_data), 0);
    req_valid = '0;
    step(); write_reset_n = 1'b1;
    do_reset();

    // Solo requester 2: first write one cycle after valid, then A1, A2, A3 back to back.
    sbq.push_back(8'hA1); sbq.push_back(8'hA2); sbq.push_back(8'hA3);
    step(); req_valid = 4'b0100; req_data[2*Dw +: Dw] = 8'hA1; #3;
    check("solo_latency_inc", 32'(write_inc), 0);
    step(); #3;
    check("solo_a1_inc", 32'(write_inc), 1);
    check("solo_a1_ready", 32'(req_ready), 32'h4);
    step(); req_data[2*Dw +: Dw] = 8'hA2; #3;
    check("solo_a2_inc", 32'(write_inc), 1);
    step(); req_data[2*Dw +: Dw] = 8'hA3; #3;
    check("solo_a3_data", 32'(write_data), 32'hA3);
    step(); req_valid = '0; #3;
    check("solo_drop_no_write", 32'(write_inc), 0);
    step(); #3;
    check("solo_back_idle", 32'(grant_valid), 0);
    do_reset();
    set_data();

`ifndef ARB_BURST_EN
    // Rotation, 5-cycle full stall on holder 1, valid drops after beats, idle recovery.
    add(4'b1111, 0, 0, 0, 0, 4'b0000);
    add(4'b1111, 0, 1, 0, 1, 4'b0001);
    add(4'b1111, 0, 1, 1, 1, 4'b0010);
    add(4'b1111, 0, 1, 2, 1, 4'b0100);
    add(4'b1111, 0, 1, 3, 1, 4'b1000);
    add(4'b1111, 0, 1, 0, 1, 4'b0001);
    for (int k = 0; k < 5; k++) add(4'b1111, 1, 1, 1, 0, 4'b0000);
    add(4'b1111, 0, 1, 1, 1, 4'b0010);
    add(4'b1111, 0, 1, 2, 1, 4'b0100);
    add(4'b1111, 0, 1, 3, 1, 4'b1000);
    add(4'b0111, 0, 1, 0, 1, 4'b0001);
    add(4'b0110, 0, 1, 1, 1, 4'b0010);
    add(4'b0100, 0, 1, 2, 1, 4'b0100);
    add(4'b0000, 0, 1, 2, 0, 4'b0100);
    add(4'b0000, 0, 0, 0, 0, 4'b0000);
    add(4'b1010, 0, 0, 0, 0, 4'b0000);
    add(4'b1010, 0, 1, 3, 1, 4'b1000);
    add(4'b0010, 0, 1, 1, 1, 4'b0010);
    add(4'b0000, 0, 1, 1, 0, 4'b0010);
    add(4'b0000, 0, 0, 0, 0, 4'b0000);
    for (int r = 0; r < tbl.size(); r++) begin
      step();
      req_valid  = tbl[r].valid;
      write_full = tbl[r].full;
      if (tbl[r].inc) sbq.push_back(8'hC0 + 8'(tbl[r].gid));
      #3;
      check($sformatf("vec%0d_gv", r), 32'(grant_valid), 32'(tbl[r].gv));
      if (tbl[r].gv) check($sformatf("vec%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
      check($sformatf("vec%0d_inc", r), 32'(write_inc), 32'(tbl[r].inc));
      check($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
      check($sformatf("vec%0d_data", r), 32'(write_data),
            tbl[r].gv ? 32'(8'hC0 + 8'(tbl[r].gid)) : 32'h0);
    end
`else
    // Bursts of four with requesters 0 and 1 continuously valid.
    burst_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    step(); req_valid = 4'b0011; #3;
    check("burst_idle_gv", 32'(grant_valid), 0);
    for (int k = 0; k < 9; k++) begin
      step();
      sbq.push_back(8'hC0 + 8'(burst_seq[k]));
      #3;
      check($sformatf("burst%0d_gid", k), 32'(grant_id), 32'(burst_seq[k]));
      check($sformatf("burst%0d_inc", k), 32'(write_inc), 1);
    end
    step(); req_valid = '0; #3;
    check("burst_drop_inc", 32'(write_inc), 0);
    step(); #3;
    check("burst_idle_after", 32'(grant_valid), 0);
`endif

    step(); #3;
    check("sb_drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
